piso_tx_scheduler: RTL

- Shares one 8-bit parallel-in/serial-out shifter between NUM_REQ requesters using round-robin arbitration.
- Accepts one byte per grant through a req/ack handshake, then shifts it out LSB-first, one bit per clock.
- Inserts a programmable idle gap between frames.
- Replaces free-running "load every eighth cycle" sequencing with explicit, handshaked frame control.

---
 rtl/piso_tx_scheduler_pkg.sv | 24 ++
 rtl/piso_tx_scheduler_shift8.sv | 28 ++
 rtl/piso_tx_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_scheduler_pkg.sv
// Shared constants for the round-robin PISO transmit scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only). Parity build is selected by PISO_TX_PARITY_EN.
package piso_tx_scheduler_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Bits per frame: the data byte, plus an even-parity bit when enabled
`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  // Width of grant_id and the round-robin pointer (covers up to 8 requesters)
  localparam int GID_W = 3;

  // Width of the in-frame bit counter (holds 0..8)
  localparam int CNT_W = 4;

endpackage

// File: rtl/piso_tx_scheduler_shift8.sv
// 8-bit load/shift register; bit0 is the next serial bit, zeros fill from the top.
// Latency: loaded byte appears on bit0_o one clock after load_i.
// Backpressure: none; load_i has priority over shift_en_i.
module piso_shift8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       shift_en_i,
  input  logic [7:0] load_dat_i,
  output logic       bit0_o
);

  logic [7:0] sr_q;

  // Load a fresh byte or shift right one place, filling with zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= 8'h00;
    end else if (load_i) begin
      sr_q <= load_dat_i;
    end else if (shift_en_i) begin
      sr_q <= {1'b0, sr_q[7:1]};
    end
  end

  assign bit0_o = sr_q[0];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler feeding one shared PISO shifter; LSB-first frames with idle gaps.
// Latency: req sampled -> ack pulse and first frame bit one clock later; frame = FRAME_BITS clocks.
// Backpressure: requesters hold req until ack; requests seen during SHIFT/GAP wait. Parity: PISO_TX_PARITY_EN.
module piso_tx_scheduler
  import piso_tx_scheduler_pkg::*;
#(
  parameter int   NUM_REQ    = 4,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 serial_out,
  output logic                 frame_valid,
  output logic                 busy,
  output logic [GID_W-1:0]     grant_id
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         gap_q, gap_d;
  logic [GID_W-1:0]   ptr_q, ptr_d;
  logic [GID_W-1:0]   gid_q, gid_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               fv_q, fv_d;

  logic               win_vld;
  logic [GID_W-1:0]   win_idx;
  logic [GID_W-1:0]   win_nxt;
  logic [NUM_REQ-1:0] win_oh;
  logic [7:0]         win_dat;

  logic               do_arb;
  logic               load;
  logic               shift_en;
  logic               sr_bit0;

  // Round-robin pick: first asserted req scanning from the pointer, wrapping
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_nxt = '0;
    win_oh  = '0;
    win_dat = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_vld && req[j] && (j == ((int'(ptr_q) + i) % NUM_REQ))) begin
          win_vld    = 1'b1;
          win_idx    = GID_W'(j);
          win_nxt    = GID_W'((j + 1) % NUM_REQ);
          win_oh[j]  = 1'b1;
          win_dat    = data[j*8 +: 8];
        end
      end
    end
  end

  // Frame sequencing. Arbitration happens in IDLE, at the last frame bit when
  // there is no gap, and at gap exit, so the line idles exactly GAP_CYCLES clocks.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    fv_d     = fv_q;
    ack_d    = '0;
    do_arb   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        do_arb = win_vld;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
          cnt_d = '0;
          fv_d  = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
            do_arb  = win_vld;
          end else begin
            state_d = ST_GAP;
            gap_d   = 4'd1;
          end
        end else begin
          cnt_d    = cnt_q + 1'b1;
          shift_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q >= 4'(GAP_CYCLES)) begin
          state_d = ST_IDLE;
          do_arb  = win_vld;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (do_arb) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      fv_d    = 1'b1;
      ack_d   = win_oh;
      gid_d   = win_idx;
      ptr_d   = win_nxt;
    end
  end

  assign load = do_arb;

  // Control state registers; reset aborts any frame in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= 4'd0;
      ptr_q   <= '0;
      gid_q   <= '0;
      ack_q   <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      fv_q    <= fv_d;
    end
  end

  piso_shift8 u_shift (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (load),
    .shift_en_i (shift_en),
    .load_dat_i (win_dat),
    .bit0_o     (sr_bit0)
  );

`ifdef PISO_TX_PARITY_EN
  logic par_q;

  // Even parity of the granted byte, sent as the ninth frame bit
  always_ff @(posedge clock) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^win_dat;
    end
  end

  // Serial line: data bits, then parity, else the idle level
  always_comb begin
    serial_out = IDLE_LEVEL;
    if (fv_q) begin
      serial_out = (cnt_q == CNT_W'(8)) ? par_q : sr_bit0;
    end
  end
`else
  // Serial line: shifter bit0 during a frame, else the idle level
  always_comb begin
    serial_out = IDLE_LEVEL;
    if (fv_q) begin
      serial_out = sr_bit0;
    end
  end
`endif

  assign ack         = ack_q;
  assign frame_valid = fv_q;
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = gid_q;

endmodule
